instr_fetch: RTL and testbench

Instruction fetch stage for the single-issue MIPS core: owns the program counter, issues word reads to instruction memory, and delivers one instruction plus its PC+4 per handshake to the decode stage, where `id_opcode` feeds the control unit. It is the producing end of the opcode path. It also absorbs the control unit's flow-change decisions (taken beq/bne, j/jal, jr) and redirects the PC, squashing any wrong-path fetch in flight. One memory request is outstanding at a time; there is a single output register and a one-entry hold buffer.

---
 rtl/instr_fetch.sv | 160 ++++++++++++++++
 tb/tb_instr_fetch.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, keeps one instruction-memory read in flight,
// and hands instruction + PC+4 to decode through an output register and a one-entry hold buffer.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] id_instr,
  output logic [5:0]  id_opcode,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  input  logic        id_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] jr_target
);

  // state  | meaning
  // ISSUE  | request at pc driven this cycle
  // WAIT   | request outstanding; kill_q marks a wrong-path response
  // HOLD   | output register busy, next instruction parked in hold buffer
  localparam logic [1:0] S_ISSUE = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc4_q, out_pc4_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc4_q, hold_pc4_d;

  logic        xfer;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] pc_inc;

  assign xfer     = out_valid_q & id_ready;
  assign pc_inc   = pc_q + 32'd4;
  assign redirect = jump_reg | branch_taken | jump;

  always_comb begin
    if (jump_reg)
      redirect_target = jr_target;
    else if (branch_taken)
      redirect_target = branch_target;
    else
      redirect_target = {out_pc4_q[31:28], jump_index, 2'b00};
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_pc4_d    = out_pc4_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;

    if (xfer)
      out_valid_d = 1'b0;

    if (redirect) begin
      // A redirect wins over any same-cycle fetch result or decode transfer.
      pc_d         = redirect_target;
      out_valid_d  = 1'b0;
      hold_instr_d = '0;
      hold_pc4_d   = '0;
      unique case (state_q)
        S_ISSUE: begin
          kill_d  = 1'b1;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_valid) begin
            kill_d  = 1'b0;
            state_d = S_ISSUE;
          end else begin
            kill_d  = 1'b1;
          end
        end
        default: state_d = S_ISSUE;
      endcase
    end else begin
      unique case (state_q)
        S_ISSUE: state_d = S_WAIT;
        S_WAIT: begin
          if (imem_valid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = S_ISSUE;
            end else begin
              pc_d = pc_inc;
              if (!out_valid_q || xfer) begin
                out_valid_d = 1'b1;
                out_instr_d = imem_rdata;
                out_pc4_d   = pc_inc;
                state_d     = S_ISSUE;
              end else begin
                hold_instr_d = imem_rdata;
                hold_pc4_d   = pc_inc;
                state_d      = S_HOLD;
              end
            end
          end
        end
        S_HOLD: begin
          if (xfer) begin
            out_valid_d = 1'b1;
            out_instr_d = hold_instr_q;
            out_pc4_d   = hold_pc4_q;
            state_d     = S_ISSUE;
          end
        end
        default: state_d = S_ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_ISSUE;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_pc4_q    <= '0;
      hold_instr_q <= '0;
      hold_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc4_q    <= out_pc4_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
    end
  end

  // Reset leaves the state at ISSUE, so the request must be gated by rst itself.
  assign imem_req  = (state_q == S_ISSUE) && !rst;
  assign imem_addr = pc_q;
  assign id_instr  = out_instr_q;
  assign id_opcode = out_instr_q[31:26];
  assign id_pc4    = out_pc4_q;
  assign id_valid  = out_valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: behavioural instruction memory with programmable latency,
// queued expected requests/deliveries checked by an independent monitor.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] id_instr;
  logic [5:0]  id_opcode;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic        id_ready = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [25:0] jump_index = '0;
  logic        jump_reg = 1'b0;
  logic [31:0] jr_target = '0;

  int checks = 0;
  int errors = 0;
  int mem_lat = 1;
  int mem_cnt = 0;
  logic mem_pend = 1'b0;
  logic [31:0] mem_addr_q = '0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_pc4_q[$];

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0040)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .id_instr(id_instr), .id_opcode(id_opcode), .id_pc4(id_pc4),
    .id_valid(id_valid), .id_ready(id_ready),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_index(jump_index),
    .jump_reg(jump_reg), .jr_target(jr_target)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A00_0000;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Instruction memory: responds mem_lat cycles after the request cycle.
  initial begin
    imem_valid = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        mem_pend   = 1'b0;
        imem_valid = 1'b0;
      end else begin
        imem_valid = 1'b0;
        if (mem_pend) begin
          mem_cnt = mem_cnt - 1;
          if (mem_cnt == 0) begin
            imem_valid = 1'b1;
            imem_rdata = mem_word(mem_addr_q);
            mem_pend   = 1'b0;
          end
        end
        if (imem_req) begin
          mem_pend   = 1'b1;
          mem_cnt    = mem_lat;
          mem_addr_q = imem_addr;
        end
      end
    end
  end

  // Monitor: every request and every decode transfer must match the next expected entry.
  initial begin
    logic [31:0] e;
    logic [31:0] e_instr;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (imem_req) begin
          if (exp_addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: got addr %h, none expected", imem_addr);
          end else begin
            e = exp_addr_q.pop_front();
            check32("req_addr", imem_addr, e);
          end
        end
        if (id_valid && id_ready && !(jump_reg || branch_taken || jump)) begin
          if (exp_pc4_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_delivery: got pc4 %h, none expected", id_pc4);
          end else begin
            e       = exp_pc4_q.pop_front();
            e_instr = mem_word(e - 32'd4);
            check32("deliver_pc4", id_pc4, e);
            check32("deliver_instr", id_instr, e_instr);
            check32("deliver_opcode", {26'b0, id_opcode}, {26'b0, e_instr[31:26]});
          end
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    checkb({tag, "_req"}, imem_req, 1'b0);
    checkb({tag, "_valid"}, id_valid, 1'b0);
    check32({tag, "_instr"}, id_instr, 32'h0);
    check32({tag, "_pc4"}, id_pc4, 32'h0);
    check32({tag, "_addr"}, imem_addr, 32'h0000_0040);
  endtask

  // Leaves the caller at the negedge of cycle 0, reset just released.
  task automatic start_test(input int lat, input logic rdy);
    @(negedge clk);
    rst = 1'b1;
    branch_taken = 1'b0;
    jump = 1'b0;
    jump_reg = 1'b0;
    id_ready = rdy;
    mem_lat = lat;
    @(negedge clk);
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic end_test(input string name);
    @(negedge clk);
    rst = 1'b1;
    #2;
    check32({name, "_reqs_left"}, exp_addr_q.size(), 32'd0);
    check32({name, "_deliv_left"}, exp_pc4_q.size(), 32'd0);
    exp_addr_q.delete();
    exp_pc4_q.delete();
  endtask

  initial begin
    // Sequential fetch, L=1.
    exp_addr_q = '{32'h40, 32'h44, 32'h48, 32'h4C};
    exp_pc4_q  = '{32'h44, 32'h48, 32'h4C};
    start_test(1, 1'b1);
    for (int n = 0; n <= 6; n++) begin
      if (n > 0) @(negedge clk);
      #2;
      checkb("seq_valid_cadence", id_valid, (n >= 2) && (n % 2 == 0));
    end
    end_test("seq");

    // Back-pressure: output register then hold buffer fill, no further requests.
    exp_addr_q = '{32'h40, 32'h44, 32'h48, 32'h4C};
    exp_pc4_q  = '{32'h44, 32'h48, 32'h4C};
    start_test(1, 1'b0);
    for (int n = 0; n <= 9; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 6) id_ready = 1'b1;
      #2;
      if (n >= 4 && n <= 6) checkb("hold_no_req", imem_req, 1'b0);
      if (n >= 2 && n <= 7) checkb("hold_valid", id_valid, 1'b1);
    end
    end_test("hold");

    // jr to 0x1000_0004, then j with index 0x10 using id_pc4 = 0x1000_0008.
    exp_addr_q = '{32'h40, 32'h1000_0004, 32'h1000_0008, 32'h1000_0040, 32'h1000_0044};
    exp_pc4_q  = '{32'h1000_0044};
    start_test(1, 1'b0);
    for (int n = 0; n <= 8; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 0) begin jump_reg = 1'b1; jr_target = 32'h1000_0004; end
      if (n == 1) jump_reg = 1'b0;
      if (n == 4) begin jump = 1'b1; jump_index = 26'h000_0010; end
      if (n == 5) jump = 1'b0;
      if (n == 8) id_ready = 1'b1;
      #2;
      if (n == 4) begin
        check32("jump_src_pc4", id_pc4, 32'h1000_0008);
        checkb("jump_src_valid", id_valid, 1'b1);
      end
      if (n == 5) checkb("jump_clears_valid", id_valid, 1'b0);
      if (n == 6) begin
        checkb("jump_req", imem_req, 1'b1);
        check32("jump_addr", imem_addr, 32'h1000_0040);
      end
    end
    end_test("jump");

    // L=3, jr one cycle after a request: stale response discarded.
    exp_addr_q = '{32'h40, 32'h200, 32'h204};
    exp_pc4_q  = '{32'h204};
    start_test(3, 1'b1);
    for (int n = 0; n <= 8; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 1) begin jump_reg = 1'b1; jr_target = 32'h0000_0200; end
      if (n == 2) jump_reg = 1'b0;
      #2;
      if (n == 3) checkb("jr_wait_no_req", imem_req, 1'b0);
      if (n >= 3 && n <= 7) checkb("jr_stale_dropped", id_valid, 1'b0);
    end
    end_test("jr");

    // Branch coincident with imem_valid, jump also asserted: branch wins.
    exp_addr_q = '{32'h40, 32'h80, 32'h84};
    exp_pc4_q  = '{32'h84};
    start_test(1, 1'b1);
    for (int n = 0; n <= 4; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 1) begin
        branch_taken = 1'b1; branch_target = 32'h80;
        jump = 1'b1; jump_index = 26'h3FF_FFFF;
      end
      if (n == 2) begin branch_taken = 1'b0; jump = 1'b0; end
      #2;
      if (n == 2) begin
        checkb("br_dropped", id_valid, 1'b0);
        check32("br_addr", imem_addr, 32'h80);
      end
    end
    end_test("branch");

    // jr beats branch when both are asserted.
    exp_addr_q = '{32'h40, 32'h300, 32'h304};
    exp_pc4_q  = '{32'h304};
    start_test(1, 1'b1);
    for (int n = 0; n <= 4; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 1) begin
        branch_taken = 1'b1; branch_target = 32'h80;
        jump_reg = 1'b1; jr_target = 32'h300;
      end
      if (n == 2) begin branch_taken = 1'b0; jump_reg = 1'b0; end
    end
    end_test("prio");

    // PC wrap at 0xFFFF_FFFC, then reset mid-WAIT.
    exp_addr_q = '{32'h40, 32'hFFFF_FFFC, 32'h0};
    start_test(1, 1'b1);
    for (int n = 0; n <= 4; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 0) begin jump_reg = 1'b1; jr_target = 32'hFFFF_FFFC; end
      if (n == 1) jump_reg = 1'b0;
      if (n == 3) id_ready = 1'b0;
      #2;
      if (n == 4) begin
        checkb("wrap_valid", id_valid, 1'b1);
        check32("wrap_pc4", id_pc4, 32'h0);
        check32("wrap_instr", id_instr, mem_word(32'hFFFF_FFFC));
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #2;
    check_reset_outputs("midwait_reset");
    check32("wrap_reqs_left", exp_addr_q.size(), 32'd0);
    exp_addr_q = '{32'h40};
    id_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    end_test("restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
